// File: rtl/gem_cluster_lut_scheduler.sv
// gem_cluster_lut_scheduler: shares one GEM cluster->CSC wire/xky LUT converter
// across all cluster slots of a BX frame and aligns its results into per-slot registers.
//
// Ports:
//   clock, reset_n            40 MHz clock, asynchronous active-low reset
//   bx_strobe                 1-clk pulse, clst_in/clst_vpf_in hold a new frame
//   clst_in, clst_vpf_in      MXCLST 14-bit cluster words and their valid bits
//   lut_cluster, lut_vpf      cluster word and issue strobe to the converter
//   lut_wire_*, lut_xky_*,    converter results, valid LUT_LAT clks after issue
//   lut_me1a
//   res_wire_*, res_xky_*,    per-slot result registers
//   res_me1a, res_valid
//   frame_done                1-clk pulse, every issued result captured
//   busy                      frame in progress (capture through frame_done)
//   overflow                  1-clk pulse, bx_strobe seen while issuing/draining
//
// Build option: define GEM_SCHED_ABORT_EN to make a strobe during a frame
// abort that frame and start the new one; otherwise the new frame is dropped.

module gem_cluster_lut_scheduler #(
    parameter int MXCLST   = 8,
    parameter int MXCLSTB  = 3,
    parameter int WIREBITS = 7,
    parameter int MXXKYB   = 10,
    parameter int LUT_LAT  = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         bx_strobe,
    input  logic [14*MXCLST-1:0]         clst_in,
    input  logic [MXCLST-1:0]            clst_vpf_in,
    output logic [13:0]                  lut_cluster,
    output logic                         lut_vpf,
    input  logic [WIREBITS-1:0]          lut_wire_lo,
    input  logic [WIREBITS-1:0]          lut_wire_hi,
    input  logic [WIREBITS-1:0]          lut_wire_mi,
    input  logic [MXXKYB-1:0]            lut_xky_lo,
    input  logic [MXXKYB-1:0]            lut_xky_hi,
    input  logic [MXXKYB-1:0]            lut_xky_mi,
    input  logic                         lut_me1a,
    output logic [WIREBITS*MXCLST-1:0]   res_wire_lo,
    output logic [WIREBITS*MXCLST-1:0]   res_wire_hi,
    output logic [WIREBITS*MXCLST-1:0]   res_wire_mi,
    output logic [MXXKYB*MXCLST-1:0]     res_xky_lo,
    output logic [MXXKYB*MXCLST-1:0]     res_xky_hi,
    output logic [MXXKYB*MXCLST-1:0]     res_xky_mi,
    output logic [MXCLST-1:0]            res_me1a,
    output logic [MXCLST-1:0]            res_valid,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(LUT_LAT - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [1:0]                      r_cnt;
    logic [MXCLST-1:0][13:0]         r_shadow;
    logic [MXCLST-1:0]               r_pend;
    logic [13:0]                     r_lut_cluster;
    logic                            r_ovf;

    // Stage 0 is concurrent with lut_vpf; stage LUT_LAT lines up with the
    // converter result for that issue.
    logic [LUT_LAT:0]                r_dl_v;
    logic [LUT_LAT:0][MXCLSTB-1:0]   r_dl_s;

    logic [MXCLST-1:0][WIREBITS-1:0] r_wlo;
    logic [MXCLST-1:0][WIREBITS-1:0] r_whi;
    logic [MXCLST-1:0][WIREBITS-1:0] r_wmi;
    logic [MXCLST-1:0][MXXKYB-1:0]   r_xlo;
    logic [MXCLST-1:0][MXXKYB-1:0]   r_xhi;
    logic [MXCLST-1:0][MXXKYB-1:0]   r_xmi;
    logic [MXCLST-1:0]               r_me1a;
    logic [MXCLST-1:0]               r_valid;

    logic                            w_busy_st;
    logic                            w_accept;
    logic                            w_issue;
    logic                            w_ovf;
    logic [MXCLSTB-1:0]              w_slot;
    logic [MXCLSTB-1:0]              w_rslot;

    // Lowest-index pending slot.
    always_comb begin
        w_slot = '0;
        for (int i = MXCLST - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_slot = MXCLSTB'(i);
            end
        end
    end

    always_comb begin
        w_busy_st = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        w_ovf     = bx_strobe && w_busy_st;
`ifdef GEM_SCHED_ABORT_EN
        w_accept  = bx_strobe;
`else
        w_accept  = bx_strobe && !w_busy_st;
`endif
        w_issue     = (r_state == S_ISSUE) && (|r_pend) && !w_accept;
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_ISSUE;
        end else begin
            unique case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_ISSUE: if (r_pend == '0) w_state_nxt = S_DRAIN;
                S_DRAIN: if (r_cnt == LAT_M1) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_shadow <= '0;
            r_pend   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == S_DRAIN) ? r_cnt + 2'd1 : 2'd0;
            r_ovf   <= w_ovf;
            if (w_accept) begin
                r_shadow <= clst_in;
                r_pend   <= clst_vpf_in;
            end else if (w_issue) begin
                // Clear the lowest set bit, i.e. the slot being issued.
                r_pend <= r_pend & (r_pend - MXCLST'(1));
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lut_cluster <= '0;
            r_dl_v        <= '0;
            r_dl_s        <= '0;
        end else begin
            if (w_issue) begin
                r_lut_cluster <= r_shadow[w_slot];
            end
            r_dl_v[0] <= w_issue;
            r_dl_s[0] <= w_slot;
            for (int i = 1; i <= LUT_LAT; i++) begin
                // A new capture flushes anything still in flight.
                r_dl_v[i] <= r_dl_v[i-1] && !w_accept;
                r_dl_s[i] <= r_dl_s[i-1];
            end
        end
    end

    assign w_rslot = r_dl_s[LUT_LAT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wlo   <= '0;
            r_whi   <= '0;
            r_wmi   <= '0;
            r_xlo   <= '0;
            r_xhi   <= '0;
            r_xmi   <= '0;
            r_me1a  <= '0;
            r_valid <= '0;
        end else if (w_accept) begin
            r_valid <= '0;
        end else if (r_dl_v[LUT_LAT]) begin
            r_wlo[w_rslot]   <= lut_wire_lo;
            r_whi[w_rslot]   <= lut_wire_hi;
            r_wmi[w_rslot]   <= lut_wire_mi;
            r_xlo[w_rslot]   <= lut_xky_lo;
            r_xhi[w_rslot]   <= lut_xky_hi;
            r_xmi[w_rslot]   <= lut_xky_mi;
            r_me1a[w_rslot]  <= lut_me1a;
            r_valid[w_rslot] <= 1'b1;
        end
    end

    assign lut_cluster = r_lut_cluster;
    assign lut_vpf     = r_dl_v[0];
    assign res_wire_lo = r_wlo;
    assign res_wire_hi = r_whi;
    assign res_wire_mi = r_wmi;
    assign res_xky_lo  = r_xlo;
    assign res_xky_hi  = r_xhi;
    assign res_xky_mi  = r_xmi;
    assign res_me1a    = r_me1a;
    assign res_valid   = r_valid;
    assign frame_done  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_gem_cluster_lut_scheduler.sv
// tb_gem_cluster_lut_scheduler: directed bench for the cluster LUT scheduler,
// with a one-clock stub converter whose results are a fixed function of the word.

module tb_gem_cluster_lut_scheduler;

    logic          clock;
    logic          reset_n;
    logic          bx_strobe;
    logic [111:0]  clst_in;
    logic [7:0]    clst_vpf_in;
    logic [13:0]   lut_cluster;
    logic          lut_vpf;
    logic [6:0]    lut_wire_lo, lut_wire_hi, lut_wire_mi;
    logic [9:0]    lut_xky_lo, lut_xky_hi, lut_xky_mi;
    logic          lut_me1a;
    logic [55:0]   res_wire_lo, res_wire_hi, res_wire_mi;
    logic [79:0]   res_xky_lo, res_xky_hi, res_xky_mi;
    logic [7:0]    res_me1a;
    logic [7:0]    res_valid;
    logic          frame_done;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    gem_cluster_lut_scheduler #(
        .MXCLST   (8),
        .MXCLSTB  (3),
        .WIREBITS (7),
        .MXXKYB   (10),
        .LUT_LAT  (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bx_strobe   (bx_strobe),
        .clst_in     (clst_in),
        .clst_vpf_in (clst_vpf_in),
        .lut_cluster (lut_cluster),
        .lut_vpf     (lut_vpf),
        .lut_wire_lo (lut_wire_lo),
        .lut_wire_hi (lut_wire_hi),
        .lut_wire_mi (lut_wire_mi),
        .lut_xky_lo  (lut_xky_lo),
        .lut_xky_hi  (lut_xky_hi),
        .lut_xky_mi  (lut_xky_mi),
        .lut_me1a    (lut_me1a),
        .res_wire_lo (res_wire_lo),
        .res_wire_hi (res_wire_hi),
        .res_wire_mi (res_wire_mi),
        .res_xky_lo  (res_xky_lo),
        .res_xky_hi  (res_xky_hi),
        .res_xky_mi  (res_xky_mi),
        .res_me1a    (res_me1a),
        .res_valid   (res_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [13:0] mk(input int i, input int seed);
        logic [7:0] pad;
        pad = 8'h20 + 8'(i) + 8'(seed * 16);
        mk  = {3'(i), 3'(seed), pad};
    endfunction

    // Stub converter transfer function, packed as
    // {wire_lo, wire_hi, wire_mi, xky_lo, xky_hi, xky_mi, me1a}.
    function automatic logic [51:0] conv(input logic [13:0] c);
        logic [6:0] a;
        logic [6:0] b;
        a = c[6:0];
        b = c[13:7];
        conv = {a, b, a ^ b, c[9:0], c[13:4], c[9:0] + 10'd3, c[13]};
    endfunction

    function automatic logic [51:0] res_slot(input int i);
        res_slot = {res_wire_lo[7*i +: 7], res_wire_hi[7*i +: 7],
                    res_wire_mi[7*i +: 7], res_xky_lo[10*i +: 10],
                    res_xky_hi[10*i +: 10], res_xky_mi[10*i +: 10],
                    res_me1a[i]};
    endfunction

    // Results valid one clock after issue; all-ones when nothing was issued.
    logic [51:0] r_conv;
    always_ff @(posedge clock) begin
        r_conv <= lut_vpf ? conv(lut_cluster) : '1;
    end
    assign {lut_wire_lo, lut_wire_hi, lut_wire_mi,
            lut_xky_lo, lut_xky_hi, lut_xky_mi, lut_me1a} = r_conv;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] vpf, input int seed);
        for (int i = 0; i < 8; i++) begin
            clst_in[14*i +: 14] = mk(i, seed);
        end
        clst_vpf_in = vpf;
    endtask

    task automatic chk_res(input logic [7:0] vpf, input int seed);
        chk("res_valid", 64'(res_valid), 64'(vpf));
        for (int i = 0; i < 8; i++) begin
            if (vpf[i]) begin
                chk($sformatf("res_slot%0d", i), 64'(res_slot(i)),
                    64'(conv(mk(i, seed))));
            end
        end
    endtask

    // Called in clk 0 of a frame; returns in the frame_done clock.
    task automatic follow(input logic [7:0] vpf, input int seed,
                          input int exp_done);
        int q[$];
        int n;
        int done_at;
        for (int i = 0; i < 8; i++) begin
            if (vpf[i]) q.push_back(i);
        end
        n       = 0;
        done_at = -1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (lut_vpf) begin
                if (n < q.size()) begin
                    chk("issue_clk", 64'(k), 64'(n + 1));
                    chk("issue_word", 64'(lut_cluster), 64'(mk(q[n], seed)));
                end
                n++;
            end
            if (frame_done) begin
                done_at = k;
                break;
            end
        end
        chk("issue_count", 64'(n), 64'(q.size()));
        chk("done_clk", 64'(done_at), 64'(exp_done));
        chk_res(vpf, seed);
    endtask

    task automatic start(input logic [7:0] vpf, input int seed);
        load(vpf, seed);
        bx_strobe = 1'b1;
        tick();
        bx_strobe = 1'b0;
        chk("cap_busy", 64'(busy), 64'd1);
        chk("cap_res_valid", 64'(res_valid), 64'd0);
    endtask

    task automatic finish_idle();
        tick();
        chk("post_done", 64'(frame_done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
    endtask

    int ovf_done;

    initial begin
        reset_n     = 1'b0;
        bx_strobe   = 1'b0;
        clst_in     = '0;
        clst_vpf_in = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_lut_vpf", 64'(lut_vpf), 64'd0);
        chk("rst_lut_cluster", 64'(lut_cluster), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_wire_lo", 64'(res_wire_lo), 64'd0);
        chk("rst_res_xky_mi", 64'(res_xky_mi), 64'd0);

        // Sparse frame: slots 0,2,5,7.
        start(8'hA5, 1);
        follow(8'hA5, 1, 6);
        finish_idle();
        chk("a5_res_stable", 64'(res_valid), 64'hA5);

        // Empty frame.
        start(8'h00, 2);
        follow(8'h00, 2, 2);
        finish_idle();

        // Full frame.
        start(8'hFF, 3);
        follow(8'hFF, 3, 10);
        finish_idle();

        // Strobe during a full frame at clk 3.
        start(8'hFF, 4);
        tick();
        tick();
        tick();
        load(8'h03, 5);
        bx_strobe = 1'b1;
        tick();
        bx_strobe = 1'b0;
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_busy", 64'(busy), 64'd1);
        chk("ovf_no_done4", 64'(frame_done), 64'd0);
        tick();
        chk("ovf_clear", 64'(overflow), 64'd0);
        chk("ovf_no_done5", 64'(frame_done), 64'd0);
`ifdef GEM_SCHED_ABORT_EN
        chk("ovf_issue5", 64'(lut_cluster), 64'(mk(0, 5)));
`else
        chk("ovf_issue5", 64'(lut_cluster), 64'(mk(4, 4)));
`endif
        ovf_done = -1;
        for (int k = 6; k <= 24; k++) begin
            tick();
            if (frame_done) begin
                ovf_done = k;
                break;
            end
        end
`ifdef GEM_SCHED_ABORT_EN
        chk("ovf_done_clk", 64'(ovf_done), 64'd8);
        chk_res(8'h03, 5);
`else
        chk("ovf_done_clk", 64'(ovf_done), 64'd10);
        chk_res(8'hFF, 4);
`endif
        finish_idle();

        // Strobe coincident with frame_done.
        start(8'h06, 6);
        follow(8'h06, 6, 4);
        load(8'h81, 7);
        bx_strobe = 1'b1;
        tick();
        bx_strobe = 1'b0;
        chk("back_busy", 64'(busy), 64'd1);
        chk("back_vpf0", 64'(lut_vpf), 64'd0);
        chk("back_res_clr", 64'(res_valid), 64'd0);
        chk("back_ovf", 64'(overflow), 64'd0);
        follow(8'h81, 7, 4);
        finish_idle();

        // Reset in the middle of issuing.
        start(8'hFF, 8);
        tick();
        tick();
        chk("mid_vpf", 64'(lut_vpf), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vpf", 64'(lut_vpf), 64'd0);
        chk("mid_rst_cluster", 64'(lut_cluster), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_wire_hi", 64'(res_wire_hi), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mid_idle_vpf", 64'(lut_vpf), 64'd0);
        chk("mid_idle_busy", 64'(busy), 64'd0);
        start(8'hA5, 9);
        follow(8'hA5, 9, 6);
        finish_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
